// File: rtl/scie_issue_queue_pkg.sv
// Shared definitions for the SCIE issue queue: opcodes, datapath width,
// the request record and the opcode classifier.
package scie_issue_queue_pkg;

  localparam int XLEN      = 32;
  // Request records carry the tag in a fixed-width field; TAG_W must not exceed it.
  localparam int TAG_MAX_W = 16;

  localparam logic [6:0] OP_COEF = 7'h0B;  // coefficient load, write-only
  localparam logic [6:0] OP_PUSH = 7'h2B;  // sample push, write-only
  localparam logic [6:0] OP_COMP = 7'h3B;  // compute, returns a result

  typedef enum logic [1:0] {
    K_WRITE,
    K_COMPUTE,
    K_ILLEGAL
  } op_kind_e;

  typedef struct packed {
    logic [XLEN-1:0]      insn;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [TAG_MAX_W-1:0] tag;
  } req_t;

  function automatic op_kind_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_COEF, OP_PUSH: return K_WRITE;
      OP_COMP:          return K_COMPUTE;
      default:          return K_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/scie_fifo.sv
// Generic synchronous FIFO with occupancy count; backs both the request
// queue and the response buffer of the issue queue.
module scie_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers/count; push is ignored when full and pop when empty.
  always_comb begin
    do_push  = push_i && (count_q != FULL);
    do_pop   = pop_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage and pointers; storage is cleared too so the head never reads X.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/scie_issue_queue.sv
// In-order issue queue in front of SCIEPipelined: buffers requests, issues
// one per cycle, drops illegal opcodes, and returns compute results in order
// through a credit-protected response buffer.
module scie_issue_queue
  import scie_issue_queue_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int RDEPTH  = 2,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [XLEN-1:0]  io_req_insn,
  input  logic [XLEN-1:0]  io_req_rs1,
  input  logic [XLEN-1:0]  io_req_rs2,
  input  logic [TAG_W-1:0] io_req_tag,
  output logic             io_scie_valid,
  output logic [XLEN-1:0]  io_scie_insn,
  output logic [XLEN-1:0]  io_scie_rs1,
  output logic [XLEN-1:0]  io_scie_rs2,
  input  logic [XLEN-1:0]  io_scie_rd,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_data,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_illegal,
  output logic             io_busy
);

  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int RCW = $clog2(RDEPTH + 1);
  localparam int RW  = TAG_W + XLEN;

  req_t             req_in, head;
  logic [QCW-1:0]   req_count;
  logic             head_vld, req_push, req_pop;
  op_kind_e         head_kind;
  logic             issue_wr, issue_cmp, drop;
  int               infl, credits_used;
  logic             credit_ok;

  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;

  logic [RW-1:0]  resp_head;
  logic [RCW-1:0] resp_count;
  logic           capture, resp_pop;
  logic           unused_tag_hi;

  // Ready depends only on stored occupancy, never on this cycle's pop.
  assign io_req_ready = (req_count < QCW'(QDEPTH));
  assign req_push     = io_req_valid && io_req_ready;
  assign head_vld     = (req_count != '0);

  // Pack the incoming request into its record.
  always_comb begin
    req_in      = '0;
    req_in.insn = io_req_insn;
    req_in.rs1  = io_req_rs1;
    req_in.rs2  = io_req_rs2;
    req_in.tag  = TAG_MAX_W'(io_req_tag);
  end

  scie_fifo #(.DEPTH(QDEPTH), .WIDTH($bits(req_t))) u_req_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (req_push),
    .wdata_i (req_in),
    .pop_i   (req_pop),
    .rdata_o (head),
    .count_o (req_count)
  );

  // Issue decision: computes need a free response slot counting in-flight ones,
  // and a stalled head blocks everything behind it.
  always_comb begin
    infl = 0;
    for (int i = 0; i < LATENCY; i++) infl = infl + int'(vld_pipe_q[i]);
    credits_used = int'(resp_count) + infl;
    credit_ok    = (credits_used < RDEPTH);
    head_kind    = classify(head.insn[6:0]);
    issue_wr     = head_vld && (head_kind == K_WRITE);
    issue_cmp    = head_vld && (head_kind == K_COMPUTE) && credit_ok;
    drop         = head_vld && (head_kind == K_ILLEGAL);
  end

  assign req_pop       = issue_wr || issue_cmp || drop;
  assign io_scie_valid = issue_wr || issue_cmp;
  assign io_scie_insn  = io_scie_valid ? head.insn : '0;
  assign io_scie_rs1   = io_scie_valid ? head.rs1  : '0;
  assign io_scie_rs2   = io_scie_valid ? head.rs2  : '0;
  assign io_illegal    = drop;
  assign unused_tag_hi = ^head.tag;

  // In-flight shift: stage i holds a compute issued i+1 cycles ago.
  always_comb begin
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = issue_cmp;
    tag_pipe_d[0] = head.tag[TAG_W-1:0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  // In-flight register; reset discards computes already sent to the pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  // The last stage is the cycle in which io_scie_rd carries the result.
  assign capture  = vld_pipe_q[LATENCY-1];
  assign resp_pop = io_resp_valid && io_resp_ready;

  scie_fifo #(.DEPTH(RDEPTH), .WIDTH(RW)) u_resp_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (capture),
    .wdata_i ({tag_pipe_q[LATENCY-1], io_scie_rd}),
    .pop_i   (resp_pop),
    .rdata_o (resp_head),
    .count_o (resp_count)
  );

  assign io_resp_valid = (resp_count != '0);
  assign io_resp_data  = io_resp_valid ? resp_head[XLEN-1:0] : '0;
  assign io_resp_tag   = io_resp_valid ? resp_head[RW-1 -: TAG_W] : '0;
  assign io_busy       = head_vld || (|vld_pipe_q) || io_resp_valid;

endmodule
